dip_input_conditioner: RTL

Downstream consumer of the serial DIP/button front-end on the 8-bit processor board. It takes each parallel frame (16 switch bits + 8 button bits) published by the shift-in driver and debounces every bit across consecutive frames. It presents stable switch/button values, sticky button-press flags with a clear handshake, and a frame-loss watchdog to the processor's I/O space.

---
 rtl/dip_pkg.sv | 16 +
 rtl/dip_debounce_bit.sv | 55 +++++
 rtl/dip_input_conditioner.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/dip_pkg.sv
// dip_pkg: shared widths, FSM state type and debounce counter width for the DIP input conditioner
// Ports: none (package)
package dip_pkg;

    localparam int SW_W  = 16;
    localparam int BTN_W = 8;
    // Wide enough for DEBOUNCE_FRAMES up to 15
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        WAIT_FIRST = 2'd0,
        RUN        = 2'd1,
        LOST       = 2'd2
    } state_t;

endpackage

// File: rtl/dip_debounce_bit.sv
// dip_debounce_bit: per-bit frame debouncer holding one stable value and its disagreement counter
// Ports:
//   i_clk, i_rst_n  clock, async active-low reset
//   i_sample        captured frame bit
//   i_accept        process i_sample as a debounce step
//   i_load          copy i_sample straight into the stable value (first frame / link recovery)
//   i_flush         discard the partial count
//   o_stable        debounced value
//   o_toggle        high on the cycle whose edge flips o_stable through debouncing
module dip_debounce_bit
    import dip_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sample,
    input  logic i_accept,
    input  logic i_load,
    input  logic i_flush,
    output logic o_stable,
    output logic o_toggle
);

    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             w_diff;

    assign w_diff   = i_sample != r_stable;
    assign o_toggle = i_accept & ~i_load & ~i_flush & w_diff
                    & (r_cnt == CNT_W'(DEBOUNCE_FRAMES - 1));
    assign o_stable = r_stable;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else if (i_flush) begin
            r_cnt    <= '0;
        end else if (i_load) begin
            r_stable <= i_sample;
            r_cnt    <= '0;
        end else if (i_accept) begin
            if (!w_diff) begin
                r_cnt    <= '0;
            end else if (o_toggle) begin
                r_stable <= ~r_stable;
                r_cnt    <= '0;
            end else begin
                r_cnt    <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dip_input_conditioner.sv
// dip_input_conditioner: debounces DIP switch / button frames, tracks presses and watches for frame loss
// Optional feature macro: DIP_IRQ_EN (o_irq driven from press flags and link error; tied 0 otherwise)
// Ports:
//   i_clk, i_rst_n   clock, async active-low reset
//   i_frame_latch    active-low frame strobe, data captured on rising i_clk while low
//   i_sw_data        raw 16-bit switch frame
//   i_btn_data       raw 8-bit button frame
//   o_sw_stable      debounced switches
//   o_btn_stable     debounced buttons, 1 = pressed
//   o_btn_press      sticky press flags
//   i_clr/i_clr_mask clear strobe and per-flag clear mask
//   o_sw_changed     one-cycle pulse when any debounced switch changes
//   o_link_err       frame watchdog expired
//   o_irq            interrupt request
module dip_input_conditioner
    import dip_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int FRAME_TIMEOUT   = 64,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_frame_latch,
    input  logic [SW_W-1:0]  i_sw_data,
    input  logic [BTN_W-1:0] i_btn_data,
    output logic [SW_W-1:0]  o_sw_stable,
    output logic [BTN_W-1:0] o_btn_stable,
    output logic [BTN_W-1:0] o_btn_press,
    input  logic             i_clr,
    input  logic [BTN_W-1:0] i_clr_mask,
    output logic             o_sw_changed,
    output logic             o_link_err,
    output logic             o_irq
);

    localparam int WD_W = $clog2(FRAME_TIMEOUT + 1);

    state_t           r_state;
    logic             r_valid;
    logic [SW_W-1:0]  r_sw;
    logic [BTN_W-1:0] r_btn;
    logic [WD_W-1:0]  r_wd;
    logic [BTN_W-1:0] r_press;
    logic             r_sw_changed;
    logic             r_link_err;

    logic             w_accept;
    logic             w_load;
    logic             w_run;
    logic             w_timeout;
    logic [SW_W-1:0]  w_sw_tgl;
    logic [BTN_W-1:0] w_btn_tgl;
    logic [BTN_W-1:0] w_btn_stable;

    assign w_accept  = ~i_frame_latch;
    // Frames are captured on the accepting edge and processed one edge later
    assign w_load    = r_valid & (r_state != RUN);
    assign w_run     = r_valid & (r_state == RUN);
    // A frame arriving on the expiry edge restarts the watchdog instead
    assign w_timeout = (r_state == RUN) & ~w_accept & (r_wd == WD_W'(FRAME_TIMEOUT - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_sw    <= '0;
            r_btn   <= '0;
        end else begin
            r_valid <= w_accept;
            if (w_accept) begin
                r_sw  <= i_sw_data;
                r_btn <= BTN_ACTIVE_LOW ? ~i_btn_data : i_btn_data;
            end
        end
    end

    for (genvar i = 0; i < SW_W; i++) begin : g_sw
        dip_debounce_bit #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_bit (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_sample(r_sw[i]),
            .i_accept(w_run),
            .i_load  (w_load),
            .i_flush (w_timeout),
            .o_stable(o_sw_stable[i]),
            .o_toggle(w_sw_tgl[i])
        );
    end

    for (genvar i = 0; i < BTN_W; i++) begin : g_btn
        dip_debounce_bit #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_bit (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_sample(r_btn[i]),
            .i_accept(w_run),
            .i_load  (w_load),
            .i_flush (w_timeout),
            .o_stable(w_btn_stable[i]),
            .o_toggle(w_btn_tgl[i])
        );
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= WAIT_FIRST;
            r_wd         <= '0;
            r_press      <= '0;
            r_sw_changed <= 1'b0;
            r_link_err   <= 1'b0;
        end else begin
            r_wd         <= w_accept ? '0
                          : (r_wd == WD_W'(FRAME_TIMEOUT)) ? r_wd : r_wd + 1'b1;
            r_sw_changed <= |w_sw_tgl;
            // A toggle of a released button is a new press; set beats a same-cycle clear
            r_press      <= (r_press & ~(i_clr ? i_clr_mask : '0)) | (w_btn_tgl & ~w_btn_stable);
            case (r_state)
                WAIT_FIRST, LOST: begin
                    if (w_load) begin
                        r_state    <= RUN;
                        r_link_err <= 1'b0;
                    end
                end
                RUN: begin
                    if (w_timeout) begin
                        r_state    <= LOST;
                        r_link_err <= 1'b1;
                    end
                end
                default: r_state <= WAIT_FIRST;
            endcase
        end
    end

`ifdef DIP_IRQ_EN
    logic r_irq;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_irq <= 1'b0;
        else          r_irq <= (|r_press) | r_link_err;
    end

    assign o_irq = r_irq;
`else
    assign o_irq = 1'b0;
`endif

    assign o_btn_stable = w_btn_stable;
    assign o_btn_press  = r_press;
    assign o_sw_changed = r_sw_changed;
    assign o_link_err   = r_link_err;

endmodule
